// File: rtl/vigna_pkg.sv
// Shared constants and state encoding for the vigna load/store unit.
package vigna_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_TIMEOUT  = 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    GAP,
    REQ1,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/vigna_lsu_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
module vigna_lsu_align
  import vigna_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic        misaligned,
  output logic [3:0]  strb0,
  output logic [3:0]  strb1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata_ext
);

  logic [3:0]  mask;
  logic [7:0]  mask_wide;
  logic [63:0] wdata_wide;
  logic [31:0] rdata_sel;

  always_comb begin
    mask = 4'b1111;
    case (size)
      SIZE_B:  mask = 4'b0001;
      SIZE_H:  mask = 4'b0011;
      default: mask = 4'b1111;
    endcase

    // Steering across an 8-byte window lets the upper half feed a second beat.
    mask_wide  = {4'b0000, mask} << off;
    wdata_wide = {32'h0, wdata} << {off, 3'b000};
    strb0      = mask_wide[3:0];
    strb1      = mask_wide[7:4];
    wdata0     = wdata_wide[31:0];
    wdata1     = wdata_wide[63:32];

    rdata_sel = 32'({rdata1, rdata0} >> {off, 3'b000});
    case (size)
      SIZE_B:  rdata_ext = {{24{is_signed & rdata_sel[7]}}, rdata_sel[7:0]};
      SIZE_H:  rdata_ext = {{16{is_signed & rdata_sel[15]}}, rdata_sel[15:0]};
      default: rdata_ext = rdata_sel;
    endcase

    misaligned = ((size == SIZE_H) && (off == 2'd3)) || (size[1] && (off != 2'd0));
  end

endmodule

// File: rtl/vigna_lsu.sv
// Load/store unit: request handshake, one or two bus beats, optional bus timeout.
module vigna_lsu
  import vigna_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1,
  parameter int TIMEOUT          = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_rdata,
  output logic [31:0]           d_wdata,
  output logic [3:0]            d_wstrb
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t state_q, state_d;
  logic                  d_valid_q, d_valid_d;
  logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
  logic [31:0]           d_wdata_q, d_wdata_d;
  logic [3:0]            d_wstrb_q, d_wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_err_q, rsp_err_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  signed_q, signed_d;
  logic                  split_q, split_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata0_q, rdata0_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;

  logic        idle;
  logic [1:0]  al_size, al_off;
  logic        al_signed, al_misaligned;
  logic [31:0] al_wdata, al_rdata0;
  logic [3:0]  al_strb0, al_strb1;
  logic [31:0] al_wdata0, al_wdata1, al_rdata_ext;
  logic        beat_ack, tmo_hit;

  assign idle      = (state_q == IDLE);
  assign req_ready = idle;

  // While idle the aligner looks at the incoming request, afterwards at the latched one.
  assign al_size   = idle ? req_size : size_q;
  assign al_off    = idle ? req_addr[1:0] : off_q;
  assign al_signed = idle ? req_signed : signed_q;
  assign al_wdata  = idle ? req_wdata : wdata_q;
  assign al_rdata0 = (state_q == REQ0) ? d_rdata : rdata0_q;

  vigna_lsu_align u_align (
    .size       (al_size),
    .off        (al_off),
    .is_signed  (al_signed),
    .wdata      (al_wdata),
    .rdata0     (al_rdata0),
    .rdata1     (d_rdata),
    .misaligned (al_misaligned),
    .strb0      (al_strb0),
    .strb1      (al_strb1),
    .wdata0     (al_wdata0),
    .wdata1     (al_wdata1),
    .rdata_ext  (al_rdata_ext)
  );

  assign beat_ack = d_valid_q && d_ready;
  assign tmo_hit  = (TIMEOUT > 0) && d_valid_q && !d_ready && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    d_valid_d   = d_valid_q;
    d_addr_d    = d_addr_q;
    d_wdata_d   = d_wdata_q;
    d_wstrb_d   = d_wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    size_d      = size_q;
    off_d       = off_q;
    signed_d    = signed_q;
    split_d     = split_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    tmo_cnt_d   = tmo_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          off_d    = req_addr[1:0];
          signed_d = req_signed;
          wdata_d  = req_wdata;
          split_d  = al_misaligned;
          if (al_misaligned && !SPLIT_MISALIGNED) begin
            state_d                = RESP;
            rsp_valid_d            = 1'b1;
            rsp_rdata_d            = 32'h0;
            rsp_err_d              = 2'b00;
            rsp_err_d[ERR_MISALIGN] = 1'b1;
          end else begin
            state_d   = REQ0;
            d_valid_d = 1'b1;
            d_addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            d_wstrb_d = req_we ? al_strb0 : 4'b0000;
            d_wdata_d = req_we ? al_wdata0 : 32'h0;
            tmo_cnt_d = '0;
          end
        end
      end
      REQ0, REQ1: begin
        if (beat_ack) begin
          d_valid_d = 1'b0;
          rdata0_d  = (state_q == REQ0) ? d_rdata : rdata0_q;
          if ((state_q == REQ0) && split_q) begin
            state_d = GAP;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? 32'h0 : al_rdata_ext;
            rsp_err_d   = 2'b00;
          end
        end else if (tmo_hit) begin
          d_valid_d              = 1'b0;
          state_d                = RESP;
          rsp_valid_d            = 1'b1;
          rsp_rdata_d            = 32'h0;
          rsp_err_d              = 2'b00;
          rsp_err_d[ERR_TIMEOUT] = 1'b1;
        end else if ((TIMEOUT > 0) && d_valid_q) begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      GAP: begin
        state_d   = REQ1;
        d_valid_d = 1'b1;
        d_addr_d  = d_addr_q + ADDR_WIDTH'(32'd4);
        d_wstrb_d = we_q ? al_strb1 : 4'b0000;
        d_wdata_d = we_q ? al_wdata1 : 32'h0;
        tmo_cnt_d = '0;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      d_valid_q   <= 1'b0;
      d_addr_q    <= '0;
      d_wdata_q   <= 32'h0;
      d_wstrb_q   <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 2'b00;
      we_q        <= 1'b0;
      size_q      <= SIZE_B;
      off_q       <= 2'd0;
      signed_q    <= 1'b0;
      split_q     <= 1'b0;
      wdata_q     <= 32'h0;
      rdata0_q    <= 32'h0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      d_valid_q   <= d_valid_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      d_wstrb_q   <= d_wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      size_q      <= size_d;
      off_q       <= off_d;
      signed_q    <= signed_d;
      split_q     <= split_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign d_valid   = d_valid_q;
  assign d_addr    = d_addr_q;
  assign d_wdata   = d_wdata_q;
  assign d_wstrb   = d_wstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_vigna_lsu.sv
// Directed bench for vigna_lsu: split/timeout instance (a) and trapping instance (b).
module tb_vigna_lsu;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        d_ready = 1'b0;
  logic [31:0] d_rdata = 32'h0;

  logic        a_req_ready, a_rsp_valid, a_d_valid;
  logic [31:0] a_rsp_rdata, a_d_addr, a_d_wdata;
  logic [1:0]  a_rsp_err;
  logic [3:0]  a_d_wstrb;
  logic        b_req_ready, b_rsp_valid, b_d_valid;
  logic [31:0] b_rsp_rdata, b_d_addr, b_d_wdata;
  logic [1:0]  b_rsp_err;
  logic [3:0]  b_d_wstrb;

  int numVectors = 0;
  int numMiscompares = 0;

  always #5 clk = ~clk;

  vigna_lsu #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b1), .TIMEOUT(4)) dut_a (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .d_valid(a_d_valid), .d_ready(d_ready), .d_addr(a_d_addr),
    .d_rdata(d_rdata), .d_wdata(a_d_wdata), .d_wstrb(a_d_wstrb)
  );

  vigna_lsu #(.ADDR_WIDTH(32), .SPLIT_MISALIGNED(1'b0), .TIMEOUT(0)) dut_b (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .d_valid(b_d_valid), .d_ready(d_ready), .d_addr(b_d_addr),
    .d_rdata(d_rdata), .d_wdata(b_d_wdata), .d_wstrb(b_d_wstrb)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numVectors++;
    if (actual !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
  endtask

  task automatic doReset();
    req_valid = 1'b0;
    d_ready   = 1'b0;
    resetn    = 1'b0;
    stepClock();
    stepClock();
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        32'h80AA_BBCC, 32'h100, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vecs[1] = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h1234,     32'h0,         32'h200, 4'b1100, 32'h1234_0000, 32'h0};
    vecs[2] = '{1'b0, 2'd2, 1'b0, 32'h300, 32'h0,        32'hDEAD_BEEF, 32'h300, 4'b0000, 32'h0,        32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 2'd1, 1'b0, 32'h402, 32'h0,        32'h8001_1234, 32'h400, 4'b0000, 32'h0,        32'h0000_8001};
    vecs[4] = '{1'b0, 2'd1, 1'b1, 32'h402, 32'h0,        32'h8001_1234, 32'h400, 4'b0000, 32'h0,        32'hFFFF_8001};
    vecs[5] = '{1'b0, 2'd0, 1'b0, 32'h501, 32'h0,        32'h1122_F344, 32'h500, 4'b0000, 32'h0,        32'h0000_00F3};
    vecs[6] = '{1'b1, 2'd0, 1'b0, 32'h601, 32'hA5,       32'h0,         32'h600, 4'b0010, 32'h0000_A500, 32'h0};
    vecs[7] = '{1'b1, 2'd2, 1'b0, 32'h700, 32'hCAFE_F00D, 32'h0,        32'h700, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[8] = '{1'b0, 2'd1, 1'b1, 32'h101, 32'h0,        32'h1280_FF34, 32'h100, 4'b0000, 32'h0,        32'hFFFF_80FF};
    vecs[9] = '{1'b0, 2'd3, 1'b0, 32'h800, 32'h0,        32'h89AB_CDEF, 32'h800, 4'b0000, 32'h0,        32'h89AB_CDEF};

    // Reset state
    doReset();
    checkOutput("reset d_valid", 32'(a_d_valid), 32'd0);
    checkOutput("reset d_addr", a_d_addr, 32'h0);
    checkOutput("reset d_wstrb", 32'(a_d_wstrb), 32'd0);
    checkOutput("reset d_wdata", a_d_wdata, 32'h0);
    checkOutput("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
    checkOutput("reset rsp_rdata", a_rsp_rdata, 32'h0);
    checkOutput("reset rsp_err", 32'(a_rsp_err), 32'd0);
    checkOutput("reset req_ready", 32'(a_req_ready), 32'd1);

    // Single-beat accesses with zero-wait acknowledge
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
      stepClock();
      req_valid = 1'b0;
      checkOutput($sformatf("v%0d d_valid", i), 32'(a_d_valid), 32'd1);
      checkOutput($sformatf("v%0d d_addr", i), a_d_addr, vecs[i].exp_addr);
      checkOutput($sformatf("v%0d d_wstrb", i), 32'(a_d_wstrb), 32'(vecs[i].exp_strb));
      checkOutput($sformatf("v%0d d_wdata", i), a_d_wdata, vecs[i].exp_wdata);
      checkOutput($sformatf("v%0d req_ready busy", i), 32'(a_req_ready), 32'd0);
      d_ready = 1'b1;
      d_rdata = vecs[i].rdata;
      stepClock();
      d_ready = 1'b0;
      d_rdata = 32'h5A5A_5A5A;
      checkOutput($sformatf("v%0d rsp_valid", i), 32'(a_rsp_valid), 32'd1);
      checkOutput($sformatf("v%0d rsp_rdata", i), a_rsp_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d rsp_err", i), 32'(a_rsp_err), 32'd0);
      checkOutput($sformatf("v%0d d_valid drop", i), 32'(a_d_valid), 32'd0);
      stepClock();
      checkOutput($sformatf("v%0d rsp_valid pulse", i), 32'(a_rsp_valid), 32'd0);
      checkOutput($sformatf("v%0d req_ready idle", i), 32'(a_req_ready), 32'd1);
    end

    // Split load across a word boundary, d_ready held during the gap cycle
    doReset();
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0);
    stepClock();
    req_valid = 1'b0;
    checkOutput("split ld beat0 valid", 32'(a_d_valid), 32'd1);
    checkOutput("split ld beat0 addr", a_d_addr, 32'h1FC);
    checkOutput("split ld beat0 wstrb", 32'(a_d_wstrb), 32'd0);
    d_ready = 1'b1;
    d_rdata = 32'hDDCC_BBAA;
    stepClock();
    d_rdata = 32'hFFFF_FFFF;
    checkOutput("split ld gap valid", 32'(a_d_valid), 32'd0);
    checkOutput("split ld gap rsp", 32'(a_rsp_valid), 32'd0);
    stepClock();
    checkOutput("split ld beat1 valid", 32'(a_d_valid), 32'd1);
    checkOutput("split ld beat1 addr", a_d_addr, 32'h200);
    d_rdata = 32'h4433_2211;
    stepClock();
    d_ready = 1'b0;
    checkOutput("split ld rsp_valid", 32'(a_rsp_valid), 32'd1);
    checkOutput("split ld rsp_rdata", a_rsp_rdata, 32'h2211_DDCC);
    checkOutput("split ld rsp_err", 32'(a_rsp_err), 32'd0);
    stepClock();
    checkOutput("split ld rsp pulse", 32'(a_rsp_valid), 32'd0);

    // Split store wrapping past the top of the address space
    doReset();
    applyStimulus(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFF, 32'hAABB_CCDD);
    stepClock();
    req_valid = 1'b0;
    checkOutput("split st beat0 addr", a_d_addr, 32'hFFFF_FFFC);
    checkOutput("split st beat0 wstrb", 32'(a_d_wstrb), 32'b1000);
    checkOutput("split st beat0 wdata", a_d_wdata, 32'hDD00_0000);
    d_ready = 1'b1;
    stepClock();
    d_ready = 1'b0;
    checkOutput("split st gap valid", 32'(a_d_valid), 32'd0);
    stepClock();
    checkOutput("split st beat1 valid", 32'(a_d_valid), 32'd1);
    checkOutput("split st beat1 addr", a_d_addr, 32'h0);
    checkOutput("split st beat1 wstrb", 32'(a_d_wstrb), 32'b0111);
    checkOutput("split st beat1 wdata", a_d_wdata, 32'h00AA_BBCC);
    d_ready = 1'b1;
    stepClock();
    d_ready = 1'b0;
    checkOutput("split st rsp_valid", 32'(a_rsp_valid), 32'd1);
    checkOutput("split st rsp_rdata", a_rsp_rdata, 32'h0);
    checkOutput("split st rsp_err", 32'(a_rsp_err), 32'd0);

    // Misaligned trap on the non-splitting instance
    doReset();
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    stepClock();
    req_valid = 1'b0;
    checkOutput("trap d_valid", 32'(b_d_valid), 32'd0);
    checkOutput("trap rsp_valid", 32'(b_rsp_valid), 32'd1);
    checkOutput("trap rsp_err", 32'(b_rsp_err), 32'b01);
    checkOutput("trap rsp_rdata", b_rsp_rdata, 32'h0);
    checkOutput("trap req_ready busy", 32'(b_req_ready), 32'd0);
    stepClock();
    checkOutput("trap d_valid after", 32'(b_d_valid), 32'd0);
    checkOutput("trap rsp pulse", 32'(b_rsp_valid), 32'd0);
    checkOutput("trap req_ready idle", 32'(b_req_ready), 32'd1);

    // Timeout: four unacknowledged wait cycles abort the beat
    doReset();
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    stepClock();
    req_valid = 1'b0;
    checkOutput("tmo wait0 valid", 32'(a_d_valid), 32'd1);
    for (int c = 1; c < 4; c++) begin
      stepClock();
      checkOutput($sformatf("tmo wait%0d valid", c), 32'(a_d_valid), 32'd1);
      checkOutput($sformatf("tmo wait%0d rsp", c), 32'(a_rsp_valid), 32'd0);
    end
    stepClock();
    checkOutput("tmo d_valid drop", 32'(a_d_valid), 32'd0);
    checkOutput("tmo rsp_valid", 32'(a_rsp_valid), 32'd1);
    checkOutput("tmo rsp_err", 32'(a_rsp_err), 32'b10);
    checkOutput("tmo rsp_rdata", a_rsp_rdata, 32'h0);

    // Acknowledge in the last allowed wait cycle still succeeds
    doReset();
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    stepClock();
    req_valid = 1'b0;
    stepClock();
    stepClock();
    stepClock();
    d_ready = 1'b1;
    d_rdata = 32'h1357_9BDF;
    stepClock();
    d_ready = 1'b0;
    checkOutput("tmo edge rsp_valid", 32'(a_rsp_valid), 32'd1);
    checkOutput("tmo edge rsp_err", 32'(a_rsp_err), 32'd0);
    checkOutput("tmo edge rsp_rdata", a_rsp_rdata, 32'h1357_9BDF);

    // Reset while the first beat is outstanding
    doReset();
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h440, 32'h1234_5678);
    stepClock();
    req_valid = 1'b0;
    checkOutput("rst mid d_valid before", 32'(a_d_valid), 32'd1);
    resetn = 1'b0;
    stepClock();
    checkOutput("rst mid d_valid", 32'(a_d_valid), 32'd0);
    checkOutput("rst mid d_addr", a_d_addr, 32'h0);
    checkOutput("rst mid d_wdata", a_d_wdata, 32'h0);
    checkOutput("rst mid d_wstrb", 32'(a_d_wstrb), 32'd0);
    checkOutput("rst mid rsp_valid", 32'(a_rsp_valid), 32'd0);
    resetn  = 1'b1;
    d_ready = 1'b1;
    stepClock();
    d_ready = 1'b0;
    checkOutput("rst mid no rsp", 32'(a_rsp_valid), 32'd0);
    checkOutput("rst mid req_ready", 32'(a_req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
